// File: rtl/mips_defs.sv
// mips_defs: shared MIPS opcode, funct, ALU-control and control-FSM state encodings
package mips_defs;
  localparam logic [5:0] OP6_RTYPE = 6'b000000;
  localparam logic [5:0] OP6_LW    = 6'b100011;
  localparam logic [5:0] OP6_SW    = 6'b101011;
  localparam logic [5:0] OP6_BEQ   = 6'b000100;
  localparam logic [5:0] OP6_ADDI  = 6'b001000;
  localparam logic [5:0] OP6_J     = 6'b000010;
  localparam logic [5:0] FUNCT6_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT6_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT6_AND  = 6'b100100;
  localparam logic [5:0] FUNCT6_OR   = 6'b100101;
  localparam logic [5:0] FUNCT6_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT6_NONE = 6'b111111;
  localparam logic [1:0] ALU_ADD_ALT = 2'b00;
  localparam logic [1:0] ALU_SUB_ALT = 2'b01;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;
endpackage

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control FSM driving datapath selects, write enables and ALU control.
// Inputs: clk_i, rst_i (async, active high), op_i6/funct_i6 from IR, zero_i from ALU, mem_ready_i handshake.
// Outputs: datapath enables/selects, alu_funct_o6/alu_alt_o2 to the ALU, sticky illegal_o, debug state_o4.
module mc_ctrl_fsm
  import mips_defs::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i6,
  input  logic [5:0] funct_i6,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_en_o,
  output logic       ir_wr_o,
  output logic       i_or_d_o,
  output logic       mem_wr_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_wr_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o2,
  output logic [1:0] pc_src_o2,
  output logic [5:0] alu_funct_o6,
  output logic [1:0] alu_alt_o2,
  output logic       illegal_o,
  output logic [3:0] state_o4
);
  state_t state, next;
  logic   bad_op;
  assign bad_op = !(op_i6 inside {OP6_LW, OP6_SW, OP6_RTYPE, OP6_BEQ, OP6_ADDI, OP6_J});
  assign state_o4 = state;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_FETCH;
      illegal_o <= 1'b0;
    end else begin
      state <= next;
      if (state == S_DECODE && bad_op) illegal_o <= 1'b1;
    end
  end
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:  next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: case (op_i6)
        OP6_LW, OP6_SW: next = S_MEMADR;
        OP6_RTYPE:      next = S_RTEXEC;
        OP6_BEQ:        next = S_BEQEX;
        OP6_ADDI:       next = S_ADDIEX;
        OP6_J:          next = S_JUMP;
        default:        next = S_FETCH;
      endcase
      S_MEMADR: next = (op_i6 == OP6_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next = mem_ready_i ? S_FETCH : S_MEMWR;
      S_RTEXEC: next = S_ALUWB;
      S_ADDIEX: next = S_ADDIWB;
      default:  next = S_FETCH;
    endcase
  end
  always_comb begin
    pc_en_o      = 1'b0;
    ir_wr_o      = 1'b0;
    i_or_d_o     = 1'b0;
    mem_wr_o     = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_wr_o     = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o2 = 2'b00;
    pc_src_o2    = 2'b00;
    alu_funct_o6 = FUNCT6_NONE;
    alu_alt_o2   = ALU_ADD_ALT;
    case (state)
      S_FETCH: begin
        alu_src_b_o2 = 2'b01;
        ir_wr_o      = mem_ready_i;
        pc_en_o      = mem_ready_i;
      end
      S_DECODE: alu_src_b_o2 = 2'b11;
      S_MEMADR: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
      end
      S_MEMRD: i_or_d_o = 1'b1;
      S_MEMWB: begin
        mem_to_reg_o = 1'b1;
        reg_wr_o     = 1'b1;
      end
      S_MEMWR: begin
        i_or_d_o = 1'b1;
        mem_wr_o = 1'b1;
      end
      S_RTEXEC: begin
        alu_src_a_o  = 1'b1;
        alu_funct_o6 = funct_i6;
      end
      S_ALUWB: begin
        reg_dst_o = 1'b1;
        reg_wr_o  = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a_o = 1'b1;
        alu_alt_o2  = ALU_SUB_ALT;
        pc_src_o2   = 2'b01;
        pc_en_o     = zero_i;
      end
      S_ADDIEX: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
      end
      S_ADDIWB: reg_wr_o = 1'b1;
      S_JUMP: begin
        pc_src_o2 = 2'b10;
        pc_en_o   = 1'b1;
      end
      default: ;
    endcase
    // reset must silence every write enable even though FETCH would follow mem_ready_i
    if (rst_i) begin
      pc_en_o  = 1'b0;
      ir_wr_o  = 1'b0;
      mem_wr_o = 1'b0;
      reg_wr_o = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench for mc_ctrl_fsm using directed per-cycle state traces
module tb_mc_ctrl_fsm;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] op_i6 = 6'b0;
  logic [5:0] funct_i6 = 6'b0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b1;
  logic       pc_en_o, ir_wr_o, i_or_d_o, mem_wr_o, reg_dst_o, mem_to_reg_o, reg_wr_o, alu_src_a_o;
  logic [1:0] alu_src_b_o2, pc_src_o2, alu_alt_o2;
  logic [5:0] alu_funct_o6;
  logic       illegal_o;
  logic [3:0] state_o4;
  int         errors = 0;
  int         checks = 0;
  logic [24:0] exp_q[$];
  logic [5:0] nop = 6'b0;
  logic [5:0] nfn = 6'b0;
  bit         exp_ill = 1'b0;
  logic [24:0] got;

  mc_ctrl_fsm dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i6(op_i6), .funct_i6(funct_i6), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_en_o(pc_en_o), .ir_wr_o(ir_wr_o), .i_or_d_o(i_or_d_o),
    .mem_wr_o(mem_wr_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_wr_o(reg_wr_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o2(alu_src_b_o2), .pc_src_o2(pc_src_o2),
    .alu_funct_o6(alu_funct_o6), .alu_alt_o2(alu_alt_o2), .illegal_o(illegal_o), .state_o4(state_o4)
  );

  always #5 clk_i = ~clk_i;

  assign got = {pc_en_o, ir_wr_o, i_or_d_o, mem_wr_o, reg_dst_o, mem_to_reg_o, reg_wr_o, alu_src_a_o,
                alu_src_b_o2, pc_src_o2, alu_funct_o6, alu_alt_o2, illegal_o, state_o4};

  function automatic logic [24:0] ref_out(int st, bit mr, bit z, logic [5:0] fn, bit ill, bit r);
    logic pe = 0, iw = 0, iod = 0, mw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00, alt = 2'b00;
    logic [5:0] f = 6'b111111;
    logic [3:0] s4 = 4'(st);
    case (st)
      0:  begin sb = 2'b01; iw = mr; pe = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  iod = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iod = 1; mw = 1; end
      6:  begin sa = 1; f = fn; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; alt = mips_defs::ALU_SUB_ALT; ps = 2'b01; pe = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    if (r) begin pe = 0; iw = 0; mw = 0; rw = 0; end
    return {pe, iw, iod, mw, rd, m2r, rw, sa, sb, ps, f, alt, ill, s4};
  endfunction

  task automatic check(string name, logic [24:0] act, logic [24:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pe,iw,iod,mw,rd,m2r,rw,sa,sb,ps,funct,alt,ill,state)",
               name, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) check($sformatf("cycle@%0t", $time), got, exp_q.pop_front());
  end

  task automatic cyc(int st, bit mr = 1, bit z = 0, bit r = 0);
    @(posedge clk_i);
    #1;
    rst_i = r;
    mem_ready_i = mr;
    zero_i = z;
    op_i6 = nop;
    funct_i6 = nfn;
    exp_q.push_back(ref_out(st, mr, z, nfn, exp_ill, r));
  endtask

  initial begin
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0);
    nop = 6'b100011;
    cyc(1); cyc(2); cyc(3, 0); cyc(3, 0); cyc(3, 1); cyc(4);
    nop = 6'b000000; nfn = 6'b100010;
    cyc(0); cyc(1); cyc(6); cyc(7);
    nop = 6'b000100; nfn = 6'b000000;
    cyc(0, 1, 1); cyc(1, 1, 1); cyc(8, 1, 1);
    cyc(0); cyc(1); cyc(8, 1, 0);
    nop = 6'b111111;
    cyc(0, 0); cyc(0); cyc(1);
    exp_ill = 1;
    nop = 6'b001000;
    cyc(0); cyc(1); cyc(9); cyc(10);
    nop = 6'b000010;
    cyc(0); cyc(1, 1, 1); cyc(11, 1, 1);
    nop = 6'b101011;
    cyc(0); cyc(1); cyc(2); cyc(5, 0); cyc(5, 0);
    #6;
    rst_i = 1;
    #1;
    check("async_reset_mid_memwr", got, ref_out(0, 0, 0, nfn, 0, 1));
    exp_ill = 0;
    cyc(0, 0, 0, 1);
    cyc(0);
    cyc(1);
    repeat (3) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
